// File: rtl/vector_relu_argmax.sv
// ReLU + argmax over VECTOR_SIZE fp32 words in BRAM, optional in-place write-back.
// Latency 3N+1 cycles (write-back) or 2N+1 (read-only); start is ignored while busy.
module vector_relu_argmax #(
  parameter int          VECTOR_SIZE = 64,
  parameter int          IDX_W       = 6,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic             wb_en,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] max_idx,
  output logic [31:0]      max_val,
  output logic [31:0]      BRAM_ADDR,
  output logic [31:0]      BRAM_WRDATA,
  output logic [3:0]       BRAM_WE,
  input  logic [31:0]      BRAM_RDDATA
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_SIZE - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wb_en_q, wb_en_d;
  logic [31:0]      r_q, r_d;
  logic [IDX_W-1:0] max_idx_q, max_idx_d;
  logic [31:0]      max_val_q, max_val_d;

  logic             last;
  logic [31:0]      relu_w;
  logic [31:0]      elem_addr;

  assign last      = (idx_q == LAST_IDX);
  assign relu_w    = BRAM_RDDATA[31] ? 32'h0 : BRAM_RDDATA;
  assign elem_addr = BASE_ADDR + (32'(idx_q) << 2);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      wb_en_q   <= 1'b0;
      r_q       <= 32'h0;
      max_idx_q <= '0;
      max_val_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wb_en_q   <= wb_en_d;
      r_q       <= r_d;
      max_idx_q <= max_idx_d;
      max_val_q <= max_val_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RD;
      S_RD:   state_d = S_CAP;
      S_CAP:  state_d = wb_en_q ? S_WR : (last ? S_DONE : S_RD);
      S_WR:   state_d = last ? S_DONE : S_RD;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d     = idx_q;
    wb_en_d   = wb_en_q;
    r_d       = r_q;
    max_idx_d = max_idx_q;
    max_val_d = max_val_q;
    if (state_q == S_IDLE && start) begin
      idx_d   = '0;
      wb_en_d = wb_en;
    end
    if (state_q == S_CAP) begin
      r_d = relu_w;
      // Post-ReLU words are non-negative, so unsigned order ranks +NaN above +inf.
      if (idx_q == '0 || relu_w > max_val_q) begin
        max_idx_d = idx_q;
        max_val_d = relu_w;
      end
      if (!wb_en_q && !last) idx_d = idx_q + 1'b1;
    end
    if (state_q == S_WR && !last) idx_d = idx_q + 1'b1;
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    BRAM_ADDR   = BASE_ADDR;
    BRAM_WRDATA = 32'h0;
    BRAM_WE     = 4'h0;
    case (state_q)
      S_RD, S_CAP: BRAM_ADDR = elem_addr;
      S_WR: begin
        BRAM_ADDR   = elem_addr;
        BRAM_WRDATA = r_q;
        BRAM_WE     = 4'hF;
      end
      default: ;
    endcase
  end

  assign max_idx = max_idx_q;
  assign max_val = max_val_q;

endmodule
